// File: rtl/uart_tx_if.sv
// Transmit-side handshake and serial line bundle for uart_tx.
// The master drives a word plus a start request; the slave reports status and drives the line.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_ready;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx;

  modport master (
    output tx_data, tx_start,
    input  tx_ready, tx_busy, tx_done, tx
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_ready, tx_busy, tx_done, tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with integrated baud counter: start, LSB-first data, optional parity, stop bits.
// Every output, including the serial line, comes straight from a flop.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end_c;

  assign bit_end_c = (baud_q == CW'(CLKS_PER_BIT - 1));

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    if (state_q != IDLE) begin
      baud_d = bit_end_c ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.tx_start && ready_q) begin
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ 1'(PARITY_ODD);
          baud_d  = '0;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shift_d = shift_q >> 1;
          if (idx_q == BW'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end_c) begin
          idx_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        // idx doubles as the stop-bit counter
        if (bit_end_c) begin
          if (idx_q == BW'(STOP_BITS - 1)) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is decided from the upcoming state so tx can be a plain flop
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule
